// File: rtl/bcd_to_bin_seq_if.sv
// Start/busy/done handshake bundle for the sequential BCD-to-binary decoder.
// The master drives the request and operand; the slave returns the result and status.
interface bcd_to_bin_seq_if #(
    parameter int DIGITS = 2,
    parameter int BW     = 7
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic [BW-1:0]         bin_out;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output start, bcd_in,
        input  bin_out, busy, done, err
    );

    modport slave (
        input  start, bcd_in,
        output bin_out, busy, done, err
    );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary decoder using reverse double-dabble:
// shift the {bcd, bin} register right, then subtract 3 from every BCD digit >= 8.
module bcd_to_bin_seq #(
    parameter int DIGITS = 2,
    parameter int BW     = 7
) (
    input  logic               CLK,
    input  logic               reset,
    bcd_to_bin_seq_if.slave    bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BW;
    localparam int CNT_W = $clog2(BW + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [SR_W-1:0]    sr, sr_nxt, shifted;
    logic [BW-1:0]      bin_q, bin_nxt;
    logic               err_q, err_nxt;
    logic               busy_q, done_q;
    logic               bad_digit;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd_in[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sr_nxt    = sr;
        bin_nxt   = bin_q;
        err_nxt   = err_q;

        // One reverse double-dabble step: the BCD LSB falls into the binary MSB.
        shifted = sr >> 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (shifted[BW + 4*i +: 4] >= 4'd8) begin
                shifted[BW + 4*i +: 4] = shifted[BW + 4*i +: 4] - 4'd3;
            end
        end

        case (state)
            IDLE: begin
                if (bus.start) begin
                    sr_nxt  = {bus.bcd_in, {BW{1'b0}}};
                    cnt_nxt = '0;
                    err_nxt = 1'b0;
                    if (bad_digit) begin
                        state_nxt = DONE;
                        err_nxt   = 1'b1;
                        bin_nxt   = '0;
                    end else begin
                        state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                sr_nxt  = shifted;
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_W'(BW - 1)) begin
                    bin_nxt   = shifted[BW-1:0];
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            sr     <= '0;
            bin_q  <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            sr     <= sr_nxt;
            bin_q  <= bin_nxt;
            err_q  <= err_nxt;
            busy_q <= (state_nxt != IDLE);
            done_q <= (state_nxt == DONE);
        end
    end

    assign bus.bin_out = bin_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: expectations are queued at each start and
// popped by a monitor on every done pulse; handshake timing is checked per conversion.
module tb_bcd_to_bin_seq;
    localparam int DIGITS = 2;
    localparam int BW     = 7;

    logic CLK = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;
    logic [BW-1:0] last_bin = '0;
    logic [BW:0]   sb[$];

    bcd_to_bin_seq_if #(.DIGITS(DIGITS), .BW(BW)) vif ();

    bcd_to_bin_seq #(.DIGITS(DIGITS), .BW(BW)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (vif.slave)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard side: every done pulse must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (reset && vif.done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                logic [BW:0] e;
                e = sb.pop_front();
                check("sb_bin", vif.bin_out, e[BW-1:0]);
                check("sb_err", vif.err, e[BW]);
            end
        end
    end

    function automatic logic [7:0] bcd_add(input logic [7:0] a, input logic [7:0] b);
        logic [4:0] lo, hi;
        logic       c;
        lo = a[3:0] + b[3:0];
        c  = (lo > 9);
        if (c) lo = lo + 5'd6;
        hi = a[7:4] + b[7:4] + {4'd0, c};
        if (hi > 9) hi = hi + 5'd6;
        return {hi[3:0], lo[3:0]};
    endfunction

    // One conversion: drive start for a single edge, then check latency, busy and holds.
    task automatic conv(input logic [7:0] bcd, input logic [BW-1:0] exp_bin,
                        input logic exp_err, input bit pulse);
        int n;
        int busy_n;
        bit got;
        @(negedge CLK);
        vif.start  = 1'b1;
        vif.bcd_in = bcd;
        sb.push_back({exp_err, exp_bin});
        @(posedge CLK);
        n = 0;
        busy_n = 0;
        got = 0;
        while (n < 30) begin
            @(negedge CLK);
            if (n == 0) begin
                vif.start  = 1'b0;
                vif.bcd_in = ~bcd;
                check("err_at_accept", vif.err, exp_err);
                if (!exp_err) check("bin_hold_busy", vif.bin_out, last_bin);
            end
            if (pulse && n == 3) vif.start = 1'b1;
            if (pulse && n == 4) vif.start = 1'b0;
            if (vif.busy) busy_n++;
            if (vif.done) begin
                got = 1;
                break;
            end
            @(posedge CLK);
            n++;
        end
        check("done_seen", got, 1);
        check("latency", n, exp_err ? 0 : BW);
        check("busy_cycles", busy_n, exp_err ? 1 : BW + 1);
        if (pulse) vif.start = 1'b1;
        @(negedge CLK);
        vif.start = 1'b0;
        check("busy_fall", vif.busy, 0);
        check("done_one_cycle", vif.done, 0);
        check("bin_hold_idle", vif.bin_out, exp_bin);
        check("err_hold_idle", vif.err, exp_err);
        last_bin = exp_bin;
    endtask

    initial begin
        vif.start  = 1'b0;
        vif.bcd_in = '0;
        repeat (3) @(negedge CLK);
        check("rst_bin", vif.bin_out, 0);
        check("rst_busy", vif.busy, 0);
        check("rst_done", vif.done, 0);
        check("rst_err", vif.err, 0);
        reset = 1'b1;
        @(negedge CLK);
        check("idle_busy", vif.busy, 0);

        conv(8'h99, 7'd99, 1'b0, 0);

        // Reset in the middle of a conversion of 57.
        @(negedge CLK);
        vif.start  = 1'b1;
        vif.bcd_in = 8'h57;
        sb.push_back({1'b0, 7'd57});
        @(posedge CLK);
        @(negedge CLK);
        vif.start = 1'b0;
        repeat (2) @(negedge CLK);
        check("mid_busy_pre", vif.busy, 1);
        reset = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_bin", vif.bin_out, 0);
        check("mid_rst_busy", vif.busy, 0);
        check("mid_rst_done", vif.done, 0);
        check("mid_rst_err", vif.err, 0);
        repeat (2) @(negedge CLK);
        check("rst_hold_done", vif.done, 0);
        reset = 1'b1;
        last_bin = '0;
        conv(8'h57, 7'd57, 1'b0, 0);

        conv(8'h00, 7'd0, 1'b0, 0);
        conv(8'h10, 7'd10, 1'b0, 0);
        conv(8'h42, 7'b0101010, 1'b0, 0);
        conv(8'h3A, 7'd0, 1'b1, 0);
        conv(8'hA3, 7'd0, 1'b1, 0);
        conv(8'h05, 7'd5, 1'b0, 0);
        conv(8'h86, 7'd86, 1'b0, 1);

        // start held high: back-to-back conversions every BW+2 cycles.
        begin
            int k;
            int t[3];
            k = 0;
            @(negedge CLK);
            vif.start  = 1'b1;
            vif.bcd_in = 8'h63;
            repeat (3) sb.push_back({1'b0, 7'd63});
            for (int c = 0; c < 60 && k < 3; c++) begin
                @(negedge CLK);
                if (vif.done) begin
                    t[k] = cyc;
                    k++;
                    if (k == 3) vif.start = 1'b0;
                end
            end
            vif.start = 1'b0;
            check("held_count", k, 3);
            if (k == 3) begin
                check("held_period_1", t[1] - t[0], BW + 2);
                check("held_period_2", t[2] - t[1], BW + 2);
            end
            @(negedge CLK);
            check("held_idle", vif.busy, 0);
            last_bin = 7'd63;
        end

        // Sweep every legal operand, produced by a BCD adder chain 00, 01, ... 99.
        begin
            logic [7:0] s;
            s = 8'h00;
            for (int i = 0; i < 100; i++) begin
                conv(s, 7'(i), 1'b0, 0);
                s = bcd_add(s, 8'h01);
            end
        end

        repeat (3) @(negedge CLK);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
        $fatal(1, "watchdog");
    end
endmodule
